// File: rtl/axil_register_wr_if.sv
// AXI4-Lite write-path bundle (AW, W, B) shared by both sides of the write register slice.
// "master" drives AW/W and sinks B; "slave" is the mirror image.
interface axil_register_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axil_register_wr.sv
// AXI4-Lite write-path register slice: AW, W and B each bypassed, simple- or skid-buffered.
// Define AXIL_REGISTER_WR_DATAPATH_RESET_EN to clear payload registers on rst as well.

// Handshake: a beat moves on a rising clk edge where valid and ready are both high;
// payload must stay stable while valid is high and ready is low, and valid never waits on ready.
module axil_register_wr_chan #(
  parameter int WIDTH    = 32,
  parameter int REG_TYPE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  if (REG_TYPE == 2) begin : g_skid
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             temp_valid_reg;
    logic             out_valid_next;
    logic             temp_valid_next;
    logic             in_ready_early;
    logic             store_in_out;
    logic             store_in_temp;
    logic             store_temp_out;
    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] temp_data_reg;

    // Ready stays up unless a second beat would have nowhere to go next cycle.
    assign in_ready_early = out_ready | (!temp_valid_reg & (!out_valid_reg | !in_valid));

    always_comb begin
      out_valid_next  = out_valid_reg;
      temp_valid_next = temp_valid_reg;
      store_in_out    = 1'b0;
      store_in_temp   = 1'b0;
      store_temp_out  = 1'b0;
      if (in_ready_reg) begin
        if (out_ready || !out_valid_reg) begin
          out_valid_next = in_valid;
          store_in_out   = in_valid;
        end else begin
          temp_valid_next = in_valid;
          store_in_temp   = in_valid;
        end
      end else if (out_ready) begin
        out_valid_next  = temp_valid_reg;
        temp_valid_next = 1'b0;
        store_temp_out  = temp_valid_reg;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_ready_reg   <= 1'b0;
        out_valid_reg  <= 1'b0;
        temp_valid_reg <= 1'b0;
      end else begin
        in_ready_reg   <= in_ready_early;
        out_valid_reg  <= out_valid_next;
        temp_valid_reg <= temp_valid_next;
      end
    end

`ifdef AXIL_REGISTER_WR_DATAPATH_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data_reg  <= '0;
        temp_data_reg <= '0;
      end else begin
        if (store_in_out) begin
          out_data_reg <= in_data;
        end else if (store_temp_out) begin
          out_data_reg <= temp_data_reg;
        end
        if (store_in_temp) begin
          temp_data_reg <= in_data;
        end
      end
    end
`else
    always_ff @(posedge clk) begin
      if (store_in_out) begin
        out_data_reg <= in_data;
      end else if (store_temp_out) begin
        out_data_reg <= temp_data_reg;
      end
      if (store_in_temp) begin
        temp_data_reg <= in_data;
      end
    end
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
  end else if (REG_TYPE == 1) begin : g_simple
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             out_valid_next;
    logic             store_in;
    logic [WIDTH-1:0] out_data_reg;

    always_comb begin
      out_valid_next = out_valid_reg;
      store_in       = 1'b0;
      if (in_ready_reg) begin
        out_valid_next = in_valid;
        store_in       = in_valid;
      end else if (out_ready) begin
        out_valid_next = 1'b0;
      end
    end

    // Ready is simply "output register empty next cycle", hence one beat per two cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_ready_reg  <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        in_ready_reg  <= !out_valid_next;
        out_valid_reg <= out_valid_next;
      end
    end

`ifdef AXIL_REGISTER_WR_DATAPATH_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data_reg <= '0;
      end else if (store_in) begin
        out_data_reg <= in_data;
      end
    end
`else
    always_ff @(posedge clk) begin
      if (store_in) begin
        out_data_reg <= in_data;
      end
    end
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_data       = in_data;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
  end

endmodule

module axil_register_wr #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int AW_REG_TYPE = 1,
  parameter int W_REG_TYPE  = 1,
  parameter int B_REG_TYPE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  axil_register_wr_if.slave     s_axil,
  axil_register_wr_if.master    m_axil
);

  logic [ADDR_WIDTH+2:0]          aw_out;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_out;
  logic [1:0]                     b_out;

  axil_register_wr_chan #(
    .WIDTH    (ADDR_WIDTH + 3),
    .REG_TYPE (AW_REG_TYPE)
  ) u_aw (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_axil.awprot, s_axil.awaddr}),
    .in_valid  (s_axil.awvalid),
    .in_ready  (s_axil.awready),
    .out_data  (aw_out),
    .out_valid (m_axil.awvalid),
    .out_ready (m_axil.awready)
  );

  assign {m_axil.awprot, m_axil.awaddr} = aw_out;

  axil_register_wr_chan #(
    .WIDTH    (DATA_WIDTH + STRB_WIDTH),
    .REG_TYPE (W_REG_TYPE)
  ) u_w (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_axil.wstrb, s_axil.wdata}),
    .in_valid  (s_axil.wvalid),
    .in_ready  (s_axil.wready),
    .out_data  (w_out),
    .out_valid (m_axil.wvalid),
    .out_ready (m_axil.wready)
  );

  assign {m_axil.wstrb, m_axil.wdata} = w_out;

  // B flows back from the downstream slave to the upstream master.
  axil_register_wr_chan #(
    .WIDTH    (2),
    .REG_TYPE (B_REG_TYPE)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (m_axil.bresp),
    .in_valid  (m_axil.bvalid),
    .in_ready  (m_axil.bready),
    .out_data  (b_out),
    .out_valid (s_axil.bvalid),
    .out_ready (s_axil.bready)
  );

  assign s_axil.bresp = b_out;

endmodule

// File: doc/axil_register_wr.md
Name: axil_register_wr

Overview:
- AXI4-Lite register slice for the write path: AW, W and B channels, each independently bypassed, simple-buffered or skid-buffered.
- Inserted between an AXI-Lite master (s_ side) and slave (m_ side) to break combinational timing paths.
- Write-side companion to the read-side register slice. The two are instantiated together to form a full AXI-Lite register slice.

Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, wstrb width (bytes per word)
- AW_REG_TYPE, 1, AW channel: 0 bypass, 1 simple buffer, 2 skid buffer
- W_REG_TYPE, 1, W channel: 0 bypass, 1 simple buffer, 2 skid buffer
- B_REG_TYPE, 1, B channel: 0 bypass, 1 simple buffer, 2 skid buffer

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axil_awaddr  in  ADDR_WIDTH  slave-side write address
- s_axil_awprot  in  3  slave-side write protection
- s_axil_awvalid  in  1  AW valid
- s_axil_awready  out  1  AW ready
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  STRB_WIDTH  write byte strobes
- s_axil_wvalid  in  1  W valid
- s_axil_wready  out  1  W ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  B valid
- s_axil_bready  in  1  B ready
- m_axil_awaddr  out  ADDR_WIDTH  master-side write address
- m_axil_awprot  out  3  master-side write protection
- m_axil_awvalid  out  1  AW valid
- m_axil_awready  in  1  AW ready
- m_axil_wdata  out  DATA_WIDTH  write data
- m_axil_wstrb  out  STRB_WIDTH  write strobes
- m_axil_wvalid  out  1  W valid
- m_axil_wready  in  1  W ready
- m_axil_bresp  in  2  write response
- m_axil_bvalid  in  1  B valid
- m_axil_bready  out  1  B ready

Behaviour:
- Three channels, fully independent; no AW/W pairing or reordering inside this block. Forward direction: AW and W run s->m, B runs m->s. "in" below = source side of a channel, "out" = sink side.
- Reset: rst asserted forces all registered ready and valid outputs (s_awready, s_wready, m_bready, m_awvalid, m_wvalid, s_bvalid, plus skid temp valids) to 0 immediately, with no clock.
  - First ready assertion is 1 cycle after rst deasserts.
  - Reset mid-transfer drops any buffered beat. Resetting both ends together is the system rule.
- Type 0 (bypass): payload and valid wired in->out, ready wired out->in. Zero latency, no state.
- Type 1 (simple buffer): one output register per channel.
  - in_ready_reg <= !out_valid_next.
  - If in_ready_reg: out_valid_next = in_valid and payload is captured.
  - Else if out_ready: out_valid_next = 0.
  - Latency 1 cycle. Maximum throughput 1 beat per 2 cycles. ready and valid are never both high on the input side in consecutive accepting cycles.
- Type 2 (skid buffer): output register plus one temp register.
  - in_ready_reg <= out_ready | (!temp_valid & (!out_valid | !in_valid)).
  - When in_ready_reg is set:
    - If out_ready or !out_valid: input goes to output.
    - Otherwise: input goes to temp.
  - When in_ready_reg is clear and out_ready is high: temp moves to output and temp_valid clears.
  - Latency 1 cycle. Sustains 1 beat/cycle with out_ready held high.
  - At most 2 beats held. When full, in_ready drops the next cycle. The beat accepted in the cycle ready drops lands in temp and is never lost.
- Payload (awaddr/awprot, wdata/wstrb, bresp) is updated only on a store event. Held stable while out_valid=1 && out_ready=0 (AXI stability rule).
- Back-to-back: ordering is strictly FIFO per channel; no duplication and no drop under arbitrary ready toggling.
- Simultaneous store and drain in the same cycle on type 2: output is replaced by the new input and temp is unaffected.

Optional Feature:
- Macro: AXIL_REGISTER_WR_DATAPATH_RESET_EN.
- Defined: all payload registers (output and temp, every channel) clear to 0 on rst through the same async reset. m_axil_awaddr, m_axil_awprot, m_axil_wdata, m_axil_wstrb and s_axil_bresp read 0 after reset.
- Undefined: payload registers have no reset (saves reset fan-out). Payload is undefined until the first store. Only valid and ready are reset.

Test Plan:
- All types=1: reset, then awaddr=0x0000_1000, awprot=0, awvalid=1 for one accepted beat -> m_awvalid=1 one cycle after acceptance, with m_awaddr=0x1000. s_awready low while m_awvalid=1 && m_awready=0.
- W type=2 with m_wready=1: stream 8 beats, wdata=0..7, wstrb=0xF -> s_wready continuously high, 8 output beats in 8 consecutive cycles, in order.
- W type=2 backpressure: m_wready=0 while sending wdata=0xA, 0xB, 0xC -> s_wready drops after 2 beats are held. Release m_wready -> 0xA, 0xB, 0xC delivered in order with no loss.
- B type=1: m_bvalid=1, bresp=2'b10, s_bready=0 for 5 cycles -> s_bvalid held with s_bresp=2'b10 stable, m_bready=0. s_bready=1 -> single B beat, then m_bready returns to 1.
- All types=0: random valid/ready traffic -> outputs equal inputs combinationally in the same cycle.
- Assert rst asynchronously mid-burst (between clock edges) -> all valids and readies 0 before the next edge. With AXIL_REGISTER_WR_DATAPATH_RESET_EN defined, m_awaddr=0 and m_wdata=0.
